fb_plot_writer: RTL and testbench



---
 rtl/fb_plot_writer_pkg.sv | 23 ++
 rtl/fb_plot_writer_fifo.sv | 55 +++++
 rtl/fb_plot_writer.sv | 150 +++++++++++++++
 tb/tb_fb_plot_writer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_plot_writer_pkg.sv
// Shared screen geometry, FSM encoding and framebuffer write record.
// No logic; types and constants only.
// Not applicable: no flow control lives here.
package fb_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int FB_ADDR_W = 15;
    localparam int FB_PIXELS = SCREEN_W * SCREEN_H;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR,
        DONE
    } fb_state_t;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [2:0]           colour;
    } fb_wr_t;

endpackage

// File: rtl/fb_plot_writer_fifo.sv
// Synchronous FIFO with head data visible whenever not empty.
// Latency: a push is readable on the cycle after it is written.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/fb_plot_writer.sv
// Clips drawer pixels, queues them, writes them to the framebuffer; full-screen clear on request.
// Latency: pixel strobed in cycle N shows fb_we=1 in cycle N+2 (empty FIFO, idle output).
// Backpressure: none to the drawer (full FIFO drops and flags overflow); fb_ready stalls the output.
module fb_plot_writer #(
    parameter int DEPTH    = 16,
    parameter int SCREEN_W = fb_pkg::SCREEN_W,
    parameter int SCREEN_H = fb_pkg::SCREEN_H,
    parameter int ADDR_W   = fb_pkg::FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        vga_x,
    input  logic [6:0]        vga_y,
    input  logic [2:0]        vga_colour,
    input  logic              vga_plot,
    input  logic              clear_start,
    input  logic [2:0]        clear_colour,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_data,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic              clear_done,
    output logic              busy,
    output logic              overflow,
    output logic [7:0]        clip_count
);

    import fb_pkg::*;

    localparam logic [7:0]        X_LIM     = 8'(SCREEN_W);
    localparam logic [6:0]        Y_LIM     = 7'(SCREEN_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

    fb_state_t              state;
    fb_state_t              state_nxt;
    fb_wr_t                 pix_wr;
    fb_wr_t                 fifo_dout;
    logic [FB_ADDR_W-1:0]   y_ext;
    logic [2:0]             clr_colour;
    logic                   pix_on;
    logic                   pix_push;
    logic                   pix_clip;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   out_free;
    logic                   pop;
    logic                   clear_acc;
    logic                   clear_go;
    logic                   clear_last;

    assign pix_on   = (vga_x < X_LIM) && (vga_y < Y_LIM);
    assign pix_push = vga_plot && pix_on;
    assign pix_clip = vga_plot && !pix_on;

    // y*160 as two shifts; the row stride is tied to the 160-column screen.
    assign y_ext         = FB_ADDR_W'(vga_y);
    assign pix_wr.addr   = (y_ext << 7) + (y_ext << 5) + FB_ADDR_W'(vga_x);
    assign pix_wr.colour = vga_colour;

    assign out_free   = !fb_we || fb_ready;
    assign clear_last = fb_we && fb_ready && (fb_addr == LAST_ADDR);

    sync_fifo #(
        .W     ($bits(fb_wr_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pix_push),
        .din   (pix_wr),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear_start) state_nxt = DRAIN;
            DRAIN:   if (fifo_empty && !fb_we) state_nxt = CLEAR;
            CLEAR:   if (clear_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pixels arriving during CLEAR/DONE stay queued until the fill is finished.
    always_comb begin
        pop        = 1'b0;
        clear_acc  = 1'b0;
        clear_go   = 1'b0;
        clear_done = 1'b0;
        case (state)
            IDLE: begin
                clear_acc = clear_start;
                pop       = !fifo_empty && out_free;
            end
            DRAIN: begin
                pop      = !fifo_empty && out_free;
                clear_go = fifo_empty && !fb_we;
            end
            DONE:    clear_done = 1'b1;
            default: ;
        endcase
        busy = (state != IDLE) || !fifo_empty || fb_we;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            clr_colour <= '0;
            overflow   <= 1'b0;
            clip_count <= '0;
        end else begin
            if (clear_acc) clr_colour <= clear_colour;

            // A drop in the same cycle as an accepted clear still leaves overflow set.
            if (pix_push && fifo_full && !pop) overflow <= 1'b1;
            else if (clear_acc)                overflow <= 1'b0;

            if (pix_clip && (clip_count != 8'hFF)) clip_count <= clip_count + 8'd1;

            if (clear_go) begin
                fb_we   <= 1'b1;
                fb_addr <= '0;
                fb_data <= clr_colour;
            end else if (state == CLEAR) begin
                if (fb_we && fb_ready) begin
                    if (fb_addr == LAST_ADDR) fb_we   <= 1'b0;
                    else                      fb_addr <= fb_addr + 1'b1;
                end
            end else if (pop) begin
                fb_we   <= 1'b1;
                fb_addr <= ADDR_W'(fifo_dout.addr);
                fb_data <= fifo_dout.colour;
            end else if (fb_ready) begin
                fb_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fb_plot_writer.sv
// Directed bench: expected framebuffer writes are queued as stimulus is driven
// and checked in order as the write port completes them.
module tb_fb_plot_writer;

    typedef struct packed {
        logic [14:0] addr;
        logic [2:0]  data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clear_start;
    logic [2:0]  clear_colour;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        fb_ready;
    logic        clear_done;
    logic        busy;
    logic        overflow;
    logic [7:0]  clip_count;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_err  = 0;
    int          n_wr   = 0;
    int          n_done = 0;
    logic        prev_stall = 1'b0;
    logic [14:0] prev_addr;
    logic [2:0]  prev_data;

    fb_plot_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_we        (fb_we),
        .fb_ready     (fb_ready),
        .clear_done   (clear_done),
        .busy         (busy),
        .overflow     (overflow),
        .clip_count   (clip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Write-port monitor: scoreboard pop on each accepted write, hold check on stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_we", 32'(fb_we), 32'd1);
                chk("stall_hold_addr", 32'(fb_addr), 32'(prev_addr));
                chk("stall_hold_data", 32'(fb_data), 32'(prev_data));
            end
            if (fb_we && fb_ready) begin
                exp_t e;
                n_wr++;
                n_cmp++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_write: observed addr %0d data %0d, expected no write", fb_addr, fb_data);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("wr_addr", 32'(fb_addr), 32'(e.addr));
                    chk("wr_data", 32'(fb_data), 32'(e.data));
                end
            end
            if (clear_done) n_done++;
            prev_stall = fb_we && !fb_ready;
            prev_addr  = fb_addr;
            prev_data  = fb_data;
        end
    end

    task automatic plot(input int x, input int y, input int c);
        @(posedge clk); #1;
        vga_plot   = 1'b1;
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = 3'(c);
    endtask

    task automatic end_plot();
        @(posedge clk); #1;
        vga_plot = 1'b0;
    endtask

    task automatic expect_wr(input int a, input int c);
        exp_t e;
        e.addr = 15'(a);
        e.data = 3'(c);
        sb.push_back(e);
    endtask

    task automatic expect_clear(input int c);
        for (int i = 0; i < 19200; i++) expect_wr(i, c);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c = 0;
        do begin
            @(negedge clk); #1;
            c++;
        end while ((busy || sb.size() != 0) && c < budget);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_pending"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_clear_done(input string tag, input int budget);
        int c = 0;
        do begin
            @(negedge clk); #1;
            c++;
        end while (!clear_done && c < budget);
        chk(tag, 32'(clear_done), 32'd1);
    endtask

    initial begin
        int wr0;
        int dn0;
        int cyc;

        rst_n        = 1'b0;
        vga_x        = '0;
        vga_y        = '0;
        vga_colour   = '0;
        vga_plot     = 1'b0;
        clear_start  = 1'b0;
        clear_colour = '0;
        fb_ready     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_fb_data", 32'(fb_data), 32'd0);
        chk("rst_clear_done", 32'(clear_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_clip_count", 32'(clip_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single pixel: latency N+2 and address y*160+x.
        wr0 = n_wr;
        expect_wr(5 * 160 + 10, 3);
        plot(10, 5, 3);
        end_plot();
        @(negedge clk); #1;
        chk("lat_n1_we", 32'(fb_we), 32'd0);
        @(negedge clk); #1;
        chk("lat_n2_we", 32'(fb_we), 32'd1);
        chk("lat_n2_addr", 32'(fb_addr), 32'd810);
        chk("lat_n2_data", 32'(fb_data), 32'd3);
        wait_idle("single", 50);
        chk("single_count", 32'(n_wr - wr0), 32'd1);

        // Clipping at both edges, and the last on-screen pixel.
        expect_wr(119 * 160 + 159, 4);
        plot(160, 0, 1);
        plot(0, 120, 2);
        plot(159, 119, 4);
        end_plot();
        wait_idle("clip", 50);
        chk("clip_count_2", 32'(clip_count), 32'd2);
        chk("clip_no_overflow", 32'(overflow), 32'd0);

        // 20 plots into a stalled port: 1 in the output register + 16 queued survive.
        @(posedge clk); #1;
        fb_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < 17) expect_wr((i + 10) * 160 + 3 * i, i % 8);
            plot(3 * i, i + 10, i % 8);
        end
        end_plot();
        @(negedge clk); #1;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_head_we", 32'(fb_we), 32'd1);
        chk("ovf_head_addr", 32'(fb_addr), 32'(10 * 160));
        @(posedge clk); #1;
        fb_ready = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk); #1;
            cyc++;
        end while (sb.size() != 0 && cyc < 100);
        chk("burst_cycles", 32'(cyc), 32'd17);
        wait_idle("burst", 50);

        // Clear behind 3 queued pixels; a mid-clear pixel lands after the fill.
        fb_ready = 1'b0;
        expect_wr(1 * 160 + 1, 1);
        expect_wr(2 * 160 + 2, 2);
        expect_wr(3 * 160 + 3, 3);
        plot(1, 1, 1);
        plot(2, 2, 2);
        plot(3, 3, 3);
        @(posedge clk); #1;
        vga_plot     = 1'b0;
        clear_start  = 1'b1;
        clear_colour = 3'd5;
        expect_clear(5);
        dn0 = n_done;
        @(posedge clk); #1;
        clear_start  = 1'b0;
        clear_colour = 3'd0;
        @(negedge clk); #1;
        chk("clear_ovf_cleared", 32'(overflow), 32'd0);
        chk("clear_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            fb_ready = (k % 2 == 0);
            vga_plot = 1'b0;
            if (k == 60) begin
                expect_wr(2 * 160 + 1, 6);
                vga_plot   = 1'b1;
                vga_x      = 8'd1;
                vga_y      = 7'd2;
                vga_colour = 3'd6;
            end
        end
        @(posedge clk); #1;
        fb_ready = 1'b1;
        wait_clear_done("clear_done_seen", 30000);
        chk("clear_tail_pending", 32'(sb.size()), 32'd1);
        wait_idle("clear", 50);
        chk("clear_done_pulses", 32'(n_done - dn0), 32'd1);

        // Clip counter saturates.
        for (int i = 0; i < 258; i++) plot(200, i % 128, 0);
        end_plot();
        wait_idle("sat", 20);
        chk("clip_sat", 32'(clip_count), 32'd255);

        // Reset in the middle of a clear aborts it; the next clear restarts at 0.
        @(posedge clk); #1;
        clear_start  = 1'b1;
        clear_colour = 3'd7;
        expect_clear(7);
        @(posedge clk); #1;
        clear_start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk); #1;
            cyc++;
        end while (!(fb_we && fb_addr == 15'd499) && cyc < 2000);
        chk("rst_reach_499", 32'(fb_addr), 32'd499);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("rst_at_500", 32'(fb_addr), 32'd500);
        sb.delete();
        @(negedge clk); #1;
        chk("abort_fb_we", 32'(fb_we), 32'd0);
        chk("abort_fb_addr", 32'(fb_addr), 32'd0);
        chk("abort_fb_data", 32'(fb_data), 32'd0);
        chk("abort_clear_done", 32'(clear_done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);
        chk("abort_clip_count", 32'(clip_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_start  = 1'b1;
        clear_colour = 3'd2;
        expect_clear(2);
        dn0 = n_done;
        @(posedge clk); #1;
        clear_start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk); #1;
            cyc++;
        end while (!fb_we && cyc < 20);
        chk("restart_addr", 32'(fb_addr), 32'd0);
        chk("restart_data", 32'(fb_data), 32'd2);
        wait_clear_done("restart_done_seen", 25000);
        wait_idle("restart", 50);
        chk("restart_done_pulses", 32'(n_done - dn0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
